// File: rtl/cpu_seq_ctrl_if.sv
// Fetch bus, datapath control strobes and status between the sequencer and the rest of the micro.
interface cpu_seq_ctrl_if #(
   parameter int PC_W = 4
);
   logic [7:0]      instr;
   logic            instr_valid;
   logic            zero_flag;
   logic            resume;
   logic            fetch_req;
   logic [PC_W-1:0] pc;
   logic [1:0]      rf_rd;
   logic [1:0]      rf_rs;
   logic            rf_we;
   logic            rf_wsel;
   logic [7:0]      imm;
   logic [2:0]      alu_op;
   logic            flag_we;
   logic            halted;
   logic            illegal;

   modport master (
      input  instr, instr_valid, zero_flag, resume,
      output fetch_req, pc, rf_rd, rf_rs, rf_we, rf_wsel, imm, alu_op, flag_we, halted, illegal
   );

   modport slave (
      output instr, instr_valid, zero_flag, resume,
      input  fetch_req, pc, rf_rd, rf_rs, rf_we, rf_wsel, imm, alu_op, flag_we, halted, illegal
   );
endinterface

// File: rtl/cpu_seq_ctrl.sv
// Fetch/decode/execute sequencer: fetches bytes at pc, decodes them and issues one cycle of
// register-file / ALU / flag strobes, resolving jumps, LDI immediates and halt.
module cpu_seq_ctrl #(
   parameter int PC_W            = 4,
   parameter bit HALT_ON_ILLEGAL = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   cpu_seq_ctrl_if.master bus
);

   typedef enum logic [2:0] {
      ST_FETCH     = 3'd0,
      ST_DECODE    = 3'd1,
      ST_FETCH_IMM = 3'd2,
      ST_EXEC      = 3'd3,
      ST_HALT      = 3'd4
   } state_t;

   typedef struct packed {
      logic       rf_we;
      logic       rf_wsel;
      logic       flag_we;
      logic [2:0] alu_op;
      logic       illegal;
   } ctrl_t;

   localparam logic [3:0] OP_LDI = 4'h7;
   localparam logic [3:0] OP_JMP = 4'h8;
   localparam logic [3:0] OP_JZ  = 4'h9;
   localparam logic [3:0] OP_HLT = 4'hF;

   // Opcode to EXEC strobe set; undefined opcodes A-E only raise illegal.
   function automatic ctrl_t decode_ctrl(input logic [3:0] op);
      ctrl_t c;
      c = '0;
      case (op)
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            c.rf_we   = 1'b1;
            c.flag_we = 1'b1;
            c.alu_op  = 3'(op - 4'd1);
         end
         4'h6: begin
            c.rf_we  = 1'b1;
            c.alu_op = 3'd5;
         end
         4'h7: begin
            c.rf_we   = 1'b1;
            c.rf_wsel = 1'b1;
         end
         4'h0, 4'h8, 4'h9, 4'hF: c = '0;
         default: c.illegal = 1'b1;
      endcase
      return c;
   endfunction

   state_t          state_r;
   logic [PC_W-1:0] pc_r;
   logic [7:0]      ir_r;
   logic [7:0]      imm_r;
   logic            rf_we_r;
   logic            rf_wsel_r;
   logic            flag_we_r;
   logic [2:0]      alu_op_r;
   logic            illegal_r;
   logic            halted_r;
   logic [3:0]      op_s;
   ctrl_t           ctrl_s;

   assign op_s   = ir_r[7:4];
   assign ctrl_s = decode_ctrl(op_s);

   // Sequencer FSM; strobes default low so they only live for the single EXEC cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r   <= ST_FETCH;
         pc_r      <= '0;
         ir_r      <= 8'h00;
         imm_r     <= 8'h00;
         rf_we_r   <= 1'b0;
         rf_wsel_r <= 1'b0;
         flag_we_r <= 1'b0;
         alu_op_r  <= 3'd0;
         illegal_r <= 1'b0;
         halted_r  <= 1'b0;
      end else begin
         rf_we_r   <= 1'b0;
         rf_wsel_r <= 1'b0;
         flag_we_r <= 1'b0;
         alu_op_r  <= 3'd0;
         illegal_r <= 1'b0;
         case (state_r)
            ST_FETCH: begin
               if (bus.instr_valid) begin
                  ir_r    <= bus.instr;
                  pc_r    <= pc_r + PC_W'(1);
                  state_r <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (op_s == OP_LDI) begin
                  state_r <= ST_FETCH_IMM;
               end else if (op_s == OP_HLT) begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end else begin
                  state_r   <= ST_EXEC;
                  rf_we_r   <= ctrl_s.rf_we;
                  rf_wsel_r <= ctrl_s.rf_wsel;
                  flag_we_r <= ctrl_s.flag_we;
                  alu_op_r  <= ctrl_s.alu_op;
                  illegal_r <= ctrl_s.illegal;
               end
            end
            ST_FETCH_IMM: begin
               if (bus.instr_valid) begin
                  imm_r     <= bus.instr;
                  pc_r      <= pc_r + PC_W'(1);
                  state_r   <= ST_EXEC;
                  rf_we_r   <= ctrl_s.rf_we;
                  rf_wsel_r <= ctrl_s.rf_wsel;
                  flag_we_r <= ctrl_s.flag_we;
                  alu_op_r  <= ctrl_s.alu_op;
                  illegal_r <= ctrl_s.illegal;
               end
            end
            ST_EXEC: begin
               // zero_flag is sampled here, so a flag written by the previous EXEC is already visible
               if ((op_s == OP_JMP) || ((op_s == OP_JZ) && bus.zero_flag)) begin
                  pc_r <= ir_r[PC_W-1:0];
               end
               if (illegal_r && HALT_ON_ILLEGAL) begin
                  state_r  <= ST_HALT;
                  halted_r <= 1'b1;
               end else begin
                  state_r <= ST_FETCH;
               end
            end
            ST_HALT: begin
               if (bus.resume) begin
                  state_r  <= ST_FETCH;
                  halted_r <= 1'b0;
               end
            end
            default: begin
               state_r  <= ST_FETCH;
               halted_r <= 1'b0;
            end
         endcase
      end
   end

   // Request is a pure state decode, masked while reset is held so the bus stays quiet.
   assign bus.fetch_req = ((state_r == ST_FETCH) || (state_r == ST_FETCH_IMM)) && !rst;
   assign bus.pc        = pc_r;
   assign bus.rf_rd     = ir_r[3:2];
   assign bus.rf_rs     = ir_r[1:0];
   assign bus.rf_we     = rf_we_r;
   assign bus.rf_wsel   = rf_wsel_r;
   assign bus.imm       = imm_r;
   assign bus.alu_op    = alu_op_r;
   assign bus.flag_we   = flag_we_r;
   assign bus.halted    = halted_r;
   assign bus.illegal   = illegal_r;

endmodule

// File: doc/cpu_seq_ctrl.md
Name: cpu_seq_ctrl

Overview:
Fetch/decode/execute sequencer for the 8-bit micro. It drives the program counter and fetch handshake toward the instruction memory, and latches the returned byte into an instruction register. It then decodes the byte and issues one cycle of control strobes to the register file, ALU and flag register. It also resolves jumps and halt.

Parameters:
PC_W, 4, program counter width (program space 2^PC_W bytes; wraps)
HALT_ON_ILLEGAL, 0, 1 = undefined opcode enters HALT; 0 = treat as NOP

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
instr  in  8  instruction/immediate byte from instruction memory
instr_valid  in  1  instr valid this cycle; sampled only while fetch_req=1
zero_flag  in  1  Z flag from datapath flag register
resume  in  1  leave HALT, continue at current pc
fetch_req  out  1  request byte at pc
pc  out  PC_W  program counter / fetch address
rf_rd  out  2  destination/operand-A register index
rf_rs  out  2  source/operand-B register index
rf_we  out  1  register-file write strobe
rf_wsel  out  1  write data select: 0=ALU result, 1=imm
imm  out  8  immediate byte for LDI
alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 PASS_B
flag_we  out  1  flag register write strobe
halted  out  1  high while in HALT
illegal  out  1  one-cycle pulse on undefined opcode in EXEC

Behaviour:
- Encoding: op=ir[7:4], rd=ir[3:2], rs=ir[1:0], target=ir[PC_W-1:0].
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 MOV rd<-rs, 7 LDI rd<-next byte, 8 JMP target, 9 JZ target, F HLT. Opcodes A–E are undefined.
- Reset (async): state=FETCH, pc=0, ir=0, imm=0. All strobes are 0, fetch_req=0, halted=0, alu_op=0, rf_rd=rf_rs=0. Reset mid-fetch or mid-EXEC aborts with no strobe.
- FETCH: fetch_req=1, pc stable. The first edge with instr_valid=1 latches ir<=instr, pc<=pc+1 (mod 2^PC_W), and moves to DECODE. Without instr_valid it holds indefinitely. Same-cycle valid is allowed, so zero-wait memory costs 1 cycle.
- DECODE: 1 cycle, fetch_req=0. LDI goes to FETCH_IMM; HLT goes to HALT; all others go to EXEC.
- FETCH_IMM: same handshake as FETCH. It latches imm<=instr, pc<=pc+1, then goes to EXEC.
- EXEC: 1 cycle, then FETCH. Strobes are valid only here and are 0 in every other state.
  - ALU ops 1–5: rf_we=1, rf_wsel=0, flag_we=1, alu_op=op-1.
  - MOV: rf_we=1, rf_wsel=0, alu_op=5, flag_we=0.
  - LDI: rf_we=1, rf_wsel=1, flag_we=0.
  - JMP: pc<=target.
  - JZ: pc<=target if zero_flag=1 sampled this cycle; otherwise pc is unchanged.
  - NOP: no strobe.
  - Undefined opcode: illegal=1. If HALT_ON_ILLEGAL=1, go to HALT instead of FETCH.
- rf_rd/rf_rs follow ir in all states. A zero flag updated by an instruction's own EXEC is visible to the next instruction's JZ.
- HALT: halted=1, fetch_req=0, pc frozen. resume=1 goes to FETCH next edge. resume outside HALT is ignored.
- Latency with zero-wait memory: 3 cycles per 1-byte instruction, 4 cycles for LDI.
- pc wrap: 15+1 = 0 (PC_W=4), including the LDI immediate fetch at pc=15.

Test Plan:
1. Reset release, instr_valid tied 1, program {0x14 ADD r1,r0} -> fetch_req at pc=0; EXEC in cycle 3: rf_we=1, flag_we=1, alu_op=0, rf_rd=1, rf_rs=0; pc=1.
2. LDI: bytes 0x78,0x5A at pc 0,1 -> EXEC: rf_we=1, rf_wsel=1, rf_rd=2, imm=0x5A, pc=2; 4 cycles total.
3. JZ 0x93: once with zero_flag=1 -> next fetch at pc=3; once with zero_flag=0 -> pc=1.
4. Wait states: instr_valid low 3 cycles in FETCH -> fetch_req held, pc=0 held, no strobe; valid on 4th cycle -> normal decode.
5. HLT 0xF0 -> halted=1, fetch_req=0, pc=1 frozen for 10 cycles; resume pulse -> fetch at pc=1. Undefined 0xA0 -> illegal pulse, continues (HALT_ON_ILLEGAL=0).
6. rst asserted mid-EXEC of ADD -> rf_we/flag_we drop same cycle, pc=0; LDI at pc=15 -> imm fetched at 0, next pc=1.
